// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and a
// constant clog2 used to size the bit counter.
package serial_sub_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_sub_fsub_cell.sv
// One-bit full subtractor: d = a - b - bin, bout set when the bit underflows.
// Purely combinational, no latency, no flow control.
module fsub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub_s.sv
// Bit-serial subtractor diff = a - b, LSB first through one fsub_cell; optional ovf via SERIAL_SUB_OVF_EN.
// Latency: result valid WIDTH edges after the accepting edge; one result per WIDTH+1 cycles back-to-back.
// Backpressure: ready only in IDLE/DONE; a DONE result is held until ack, start without ack is ignored.
module serial_sub_s
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             valid,
  input  logic             ack,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] diff_sh;
  logic [WIDTH-1:0] diff_nxt;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             d;
  logic             br_next;
  logic             load;

  fsub_cell u_cell (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .bin (br),
    .d   (d),
    .bout(br_next)
  );

  assign ready    = (state == S_IDLE) || (state == S_DONE);
  assign valid    = (state == S_DONE);
  assign load     = start && ((state == S_IDLE) || ((state == S_DONE) && ack));
  assign diff_nxt = {d, diff_sh};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      diff_sh <= '0;
      cnt     <= '0;
      br      <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf     <= 1'b0;
`endif
    end else if (load) begin
      state <= S_SHIFT;
      a_sh  <= a;
      b_sh  <= b;
      cnt   <= '0;
      br    <= 1'b0;
    end else begin
      case (state)
        S_SHIFT: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          diff_sh <= diff_nxt[WIDTH-1:1];
          br      <= br_next;
          cnt     <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            // On the last bit the shifters hold the operand MSBs and d is the result MSB.
            state <= S_DONE;
            diff  <= diff_nxt;
            bout  <= br_next;
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= (a_sh[0] ^ b_sh[0]) & (a_sh[0] ^ d);
`endif
          end
        end
        S_DONE: begin
          if (ack) state <= S_IDLE;
        end
        S_IDLE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
